// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// table entry layout and PC helpers.
package bp_pkg;

    // Two-bit saturating counter states.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // An entry starts weakly not-taken; a new allocation starts weakly taken.
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Sequential fetch step.
    localparam logic [31:0] PC_STEP = 32'd4;

    // The tag field is a full word so any TAG_BITS setting fits.
    // Bits above TAG_BITS are always zero and disappear in synthesis.
    localparam int TAG_FIELD_BITS = 32;

    typedef struct packed {
        logic                      valid;
        logic [TAG_FIELD_BITS-1:0] tag;
        logic [1:0]                ctr;
        logic [31:0]               target;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        ctr:    CTR_RESET,
        target: '0
    };

    // Extract the tag bits that sit directly above the index bits,
    // zero-extended to the tag field width.
    function automatic logic [TAG_FIELD_BITS-1:0] pc_tag(
        input logic [31:0] pc,
        input int          index_bits,
        input int          tag_bits
    );
        logic [31:0] shifted;
        logic [31:0] mask;
        shifted = pc >> (index_bits + 2);
        mask    = (32'd1 << tag_bits) - 32'd1;
        return shifted & mask;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter next-state function (purely combinational).
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] ctr_next
);

    // Step toward strongly taken / strongly not-taken, holding at the ends.
    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target predictor.
// Fetch side: zero-latency lookup of if_pc. Resolve side: trains the table
// and flags mispredictions with the correct redirect PC.
// Optional macro BP_STATS_EN adds branch and mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Table is register-based: lookups are combinational and reset clears
    // every entry in one cycle.
    bp_entry_t bht_reg [ENTRIES];

    logic [INDEX_BITS-1:0]     if_idx;
    logic [TAG_FIELD_BITS-1:0] if_tag;
    bp_entry_t                 if_entry;
    logic                      if_hit;

    logic [INDEX_BITS-1:0]     upd_idx;
    logic [TAG_FIELD_BITS-1:0] upd_tag;
    bp_entry_t                 upd_entry;
    bp_entry_t                 upd_entry_next;
    logic                      upd_hit;
    logic                      upd_write;
    logic [1:0]                ctr_next;
    logic [ENTRIES-1:0]        wr_en;

    // Fetch-side lookup; reset forces a miss so the pipeline fetches sequentially.
    assign if_idx   = if_pc[INDEX_BITS+1:2];
    assign if_tag   = pc_tag(if_pc, INDEX_BITS, TAG_BITS);
    assign if_entry = bht_reg[if_idx];
    assign if_hit   = !rst && if_entry.valid && (if_entry.tag == if_tag);

    assign pred_taken  = if_hit && if_entry.ctr[1];
    assign pred_target = pred_taken ? if_entry.target : (if_pc + PC_STEP);

    // Resolve-side read of the entry being trained.
    assign upd_idx   = upd_pc[INDEX_BITS+1:2];
    assign upd_tag   = pc_tag(upd_pc, INDEX_BITS, TAG_BITS);
    assign upd_entry = bht_reg[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    bp_sat_counter u_sat_counter (
        .ctr      (upd_entry.ctr),
        .up       (upd_taken),
        .ctr_next (ctr_next)
    );

    // Build the replacement entry: train on a hit, allocate on a taken miss.
    always_comb begin
        upd_entry_next = upd_entry;
        upd_write      = 1'b0;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_write          = 1'b1;
                upd_entry_next.ctr = ctr_next;
                if (upd_taken) begin
                    upd_entry_next.target = upd_target;
                end
            end else if (upd_taken) begin
                upd_write             = 1'b1;
                upd_entry_next.valid  = 1'b1;
                upd_entry_next.tag    = upd_tag;
                upd_entry_next.ctr    = CTR_ALLOC;
                upd_entry_next.target = upd_target;
            end
        end
    end

    // One-hot write enable over the single write port.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_wr_en
            assign wr_en[gi] = upd_write && (upd_idx == INDEX_BITS'(gi));
        end
    endgenerate

    // Table state: reset wins over any same-cycle update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rst) begin
                bht_reg[i] <= ENTRY_RESET;
            end else if (wr_en[i]) begin
                bht_reg[i] <= upd_entry_next;
            end
        end
    end

    // Flush request when the carried prediction disagrees with the outcome.
    assign mispredict  = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = !upd_valid ? 32'd0 :
                         (upd_taken ? upd_target : (upd_pc + PC_STEP));

`ifdef BP_STATS_EN
    // Running totals of resolved branches and flushes, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the branch-resolve comparator.
- IF stage: predicts taken/not-taken and the target for the current PC from a direct-mapped branch history/target table.
- Resolve stage: each resolved branch outcome (is_branch) trains the table.
- Raises a mispredict/redirect to the pipeline-flush logic when the earlier prediction was wrong.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries).
- TAG_BITS, 8, PC tag bits stored per entry.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  32  fetch-stage PC.
- pred_taken  output  1  prediction for if_pc.
- pred_target  output  32  predicted next PC for if_pc.
- upd_valid  input  1  a branch resolved this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (is_branch).
- upd_target  input  32  resolved taken target.
- upd_pred_taken  input  1  prediction carried down the pipe with the branch.
- upd_pred_target  input  32  predicted next PC carried with the branch.
- mispredict  output  1  flush request.
- redirect_pc  output  32  correct next PC when mispredict=1.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Entry fields: valid(1), tag(TAG_BITS), ctr(2), target(32).
- Reset (rst high at a clk edge): every valid=0, every ctr=2'b01 (weakly not-taken), tag=0, target=0.
- Reset mid-stream: an upd_valid in the same cycle as rst is discarded.
- Outputs during reset: all lookups miss, so pred_taken=0 and pred_target=if_pc+4.
- Index and tag:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
  - Bits [1:0] are ignored.
- Lookup (combinational from table state, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
- Update (registered, takes effect at the next clk edge when upd_valid=1):
  - Hit at upd idx: ctr increments if upd_taken, else decrements. It saturates at 2'b11 and 2'b00. If upd_taken, target is overwritten with upd_target.
  - Miss, upd_taken=1: allocate the entry. valid=1, tag=upd tag, ctr=2'b10, target=upd_target. Any conflicting entry is replaced.
  - Miss, upd_taken=0: no change.
  - upd_valid=0: table unchanged.
- Simultaneous lookup and update to the same idx: the lookup returns pre-update state (no bypass). The updated value is visible the following cycle.
- Mispredict (combinational, qualified by upd_valid):
  - mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - With upd_valid=0: mispredict=0, redirect_pc=0.
- At most one update per cycle; the table has a single write port.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both are cleared by rst.
  - stat_branches increments on each upd_valid; stat_mispredicts increments when mispredict=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - Counter encodings: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Reset value CTR_RESET=CTR_WNT and allocate value CTR_ALLOC=CTR_WT.
  - Constant PC_STEP=32'd4.
  - Entry struct typedef bp_entry_t.
- Sub-module bp_sat_counter: a combinational 2-bit saturating next-state function, instantiated once on the update path.

Test Plan:
- After rst, if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014; upd_valid=0 -> mispredict=0.
- Update pc=0x00400020, taken=1, target=0x00400100, pred_taken=0 -> mispredict=1, redirect_pc=0x00400100. Next cycle if_pc=0x00400020 -> pred_taken=1, pred_target=0x00400100.
- Same entry, not-taken twice -> ctr 10->01->00. Lookup -> pred_taken=0. Third not-taken keeps ctr=00; four taken saturate ctr at 11.
- Aliasing: allocate pc 0x00400020, then taken update at pc 0x00401020 (same idx, different tag) -> entry replaced. Lookup of 0x00400020 -> miss, pred_target=0x00400024.
- Lookup and update to the same idx in one cycle -> lookup shows old state; the following cycle shows the new state. rst asserted with upd_valid=1 -> table stays at reset values.
- With BP_STATS_EN: 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst -> both 0.
